// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
//
// Drives an external 16-bit universal shift register (USR) to move one word
// out serially while the same USR captures a word coming in. A word is
// accepted with a valid/ready handshake. The USR is parallel-loaded and then
// shifted 16 times, once every CLK_DIV clocks. Finally the captured USR
// contents are presented as the received word.
//
// Parameters
//   CLK_DIV                  clocks per serial bit (1..255)
//
// Build option
//   USR_SEQ_LSB_FIRST_EN     when defined, shift right (LSB first) instead of
//                            shift left (MSB first); timing is unchanged
//
// Ports
//   Clk_In                   clock, rising edge
//   Reset_In                 synchronous active-high reset; all outputs read
//                            as their reset values while it is high
//   Tx_Valid_In/Tx_Ready_Out word handshake, Tx_Data_In latched on acceptance
//   Tx_Data_In               word to transmit
//   Abort_In                 drops a transfer in LOAD/SHIFT back to IDLE
//   Serial_Rx_In             serial receive bit, fed to both USR serial inputs
//   Serial_Tx_Out            USR outgoing edge bit while shifting, else 0
//   Bit_Strobe_Out           high on every shift cycle
//   Busy_Out                 high whenever a transfer is in progress
//   Rx_Valid_Out             one-cycle pulse with the received word
//   Rx_Data_Out              received word, held until the next pulse
//   USR_*_Out                USR control: enable, op select, serial ins, parallel in
//   USR_*_In                 USR status: serial edge outputs, parallel contents

module usr_shift_sequencer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        Clk_In,
   input  logic        Reset_In,
   input  logic        Tx_Valid_In,
   output logic        Tx_Ready_Out,
   input  logic [15:0] Tx_Data_In,
   input  logic        Abort_In,
   input  logic        Serial_Rx_In,
   output logic        Serial_Tx_Out,
   output logic        Bit_Strobe_Out,
   output logic        Busy_Out,
   output logic        Rx_Valid_Out,
   output logic [15:0] Rx_Data_Out,
   output logic        USR_Enable_Out,
   output logic [1:0]  USR_Operation_Select_Out,
   output logic        USR_Serial_Left_Side_Data_Out,
   output logic        USR_Serial_Right_Side_Data_Out,
   output logic [15:0] USR_Parallel_Data_Out,
   input  logic        USR_Serial_Left_Side_Data_In,
   input  logic        USR_Serial_Right_Side_Data_In,
   input  logic [15:0] USR_Parallel_Data_In
);

   localparam logic [1:0] OpNone = 2'd0;
   localparam logic [1:0] OpLoad = 2'd3;
   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
   localparam logic [4:0] BitLast = 5'd15;

   // Shift direction: which USR op is used and which USR edge bit leaves first.
   logic tx_bit;
`ifdef USR_SEQ_LSB_FIRST_EN
   localparam logic [1:0] OpShift = 2'd2;
   assign tx_bit = USR_Serial_Right_Side_Data_In;
   logic unused_serial;
   assign unused_serial = USR_Serial_Left_Side_Data_In;
`else
   localparam logic [1:0] OpShift = 2'd1;
   assign tx_bit = USR_Serial_Left_Side_Data_In;
   logic unused_serial;
   assign unused_serial = USR_Serial_Right_Side_Data_In;
`endif

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [4:0]  bit_q, bit_d;
   logic [15:0] word_q, word_d;
   logic [15:0] rx_data_q, rx_data_d;

   // A shift happens on the last divide count of each bit period, unless the
   // transfer is being aborted in that same cycle (the USR is then left alone).
   logic shift_tick;
   assign shift_tick = (state_q == StShift) && (div_q == DivLast) && !Abort_In;

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         state_q   <= StIdle;
         div_q     <= '0;
         bit_q     <= '0;
         word_q    <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         word_q    <= word_d;
         rx_data_q <= rx_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      word_d    = word_q;
      rx_data_d = rx_data_q;
      unique case (state_q)
         StIdle: begin
            if (Tx_Valid_In && !Abort_In) begin
               state_d = StLoad;
               word_d  = Tx_Data_In;
            end
         end
         StLoad: begin
            div_d   = '0;
            bit_d   = '0;
            state_d = Abort_In ? StIdle : StShift;
         end
         StShift: begin
            if (Abort_In) begin
               state_d = StIdle;
            end else if (div_q == DivLast) begin
               div_d = '0;
               bit_d = bit_q + 5'd1;
               if (bit_q == BitLast) begin
                  state_d = StDone;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         StDone: begin
            state_d   = StIdle;
            rx_data_d = USR_Parallel_Data_In;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are forced to their reset values for the whole reset cycle.
   always_comb begin
      Tx_Ready_Out             = 1'b0;
      Serial_Tx_Out            = 1'b0;
      Bit_Strobe_Out           = 1'b0;
      Busy_Out                 = 1'b0;
      Rx_Valid_Out             = 1'b0;
      Rx_Data_Out              = '0;
      USR_Enable_Out           = 1'b0;
      USR_Operation_Select_Out = OpNone;
      USR_Parallel_Data_Out    = '0;
      if (!Reset_In) begin
         Tx_Ready_Out   = (state_q == StIdle) && !Abort_In;
         Busy_Out       = (state_q != StIdle);
         Bit_Strobe_Out = shift_tick;
         Serial_Tx_Out  = (state_q == StShift) && tx_bit;
         Rx_Valid_Out   = (state_q == StDone);
         USR_Enable_Out = 1'b1;
         // In DONE the USR already holds the finished word; show it in the
         // same cycle as the valid pulse, then hold the registered copy.
         Rx_Data_Out    = (state_q == StDone) ? USR_Parallel_Data_In : rx_data_q;
         if ((state_q == StLoad) && !Abort_In) begin
            USR_Operation_Select_Out = OpLoad;
         end else if (shift_tick) begin
            USR_Operation_Select_Out = OpShift;
         end
         if (state_q == StLoad) begin
            USR_Parallel_Data_Out = word_q;
         end
      end
   end

   assign USR_Serial_Left_Side_Data_Out  = Serial_Rx_In;
   assign USR_Serial_Right_Side_Data_Out = Serial_Rx_In;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: a small behavioural USR is attached to the
// sequencer. A table of single-cycle vectors covers reset and handshake
// corners. Transfers, directed and random, are then checked cycle by cycle
// against a transaction-level timing model.

module tb_usr_shift_sequencer;

   localparam int DIV = 4;
`ifdef USR_SEQ_LSB_FIRST_EN
   localparam bit         LsbFirst = 1'b1;
   localparam logic [1:0] ShiftOp  = 2'd2;
`else
   localparam bit         LsbFirst = 1'b0;
   localparam logic [1:0] ShiftOp  = 2'd1;
`endif

   logic        clk = 1'b0;
   logic        rst, vld, abt, rx_drive, rx_in;
   bit          loop_mode;
   logic [15:0] data;

   logic        rdy, tx, stb, busy, rx_valid, usr_en, usr_sl, usr_sr;
   logic [1:0]  usr_op;
   logic [15:0] rx_data, usr_par;
   logic [15:0] usr_q = '0;

   int checks = 0;
   int errors = 0;
   int busy_seen;
   logic [15:0] exp_rx = '0;
   logic [15:0] txs;

   always #5 clk = ~clk;

   assign rx_in = loop_mode ? tx : rx_drive;

   usr_shift_sequencer dut (
      .Clk_In                        (clk),
      .Reset_In                      (rst),
      .Tx_Valid_In                   (vld),
      .Tx_Ready_Out                  (rdy),
      .Tx_Data_In                    (data),
      .Abort_In                      (abt),
      .Serial_Rx_In                  (rx_in),
      .Serial_Tx_Out                 (tx),
      .Bit_Strobe_Out                (stb),
      .Busy_Out                      (busy),
      .Rx_Valid_Out                  (rx_valid),
      .Rx_Data_Out                   (rx_data),
      .USR_Enable_Out                (usr_en),
      .USR_Operation_Select_Out      (usr_op),
      .USR_Serial_Left_Side_Data_Out (usr_sl),
      .USR_Serial_Right_Side_Data_Out(usr_sr),
      .USR_Parallel_Data_Out         (usr_par),
      .USR_Serial_Left_Side_Data_In  (usr_q[15]),
      .USR_Serial_Right_Side_Data_In (usr_q[0]),
      .USR_Parallel_Data_In          (usr_q)
   );

   // Behavioural universal shift register.
   always_ff @(posedge clk) begin
      if (usr_en) begin
         case (usr_op)
            2'd1:    usr_q <= {usr_q[14:0], usr_sr};
            2'd2:    usr_q <= {usr_sl, usr_q[15:1]};
            2'd3:    usr_q <= usr_par;
            default: usr_q <= usr_q;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One transfer starting in an IDLE cycle. mode: 0 random rx, 1 loopback,
   // 2 rx tied high. abort_k: abort on that shift number (0 = never).
   // rst_t: assert reset in that busy cycle (0 = never).
   task automatic xfer(input logic [15:0] word, input int mode, input bit keep,
                       input int abort_k, input int rst_t, output logic [15:0] seq);
      int T;
      int s;
      int k;
      bit stb_e;
      bit tx_e;
      bit rx_b;
      logic [15:0] res;
      logic [1:0] op_e;
      T = 2 + 16 * DIV;
      res = '0;
      seq = '0;
      busy_seen = 0;
      loop_mode = (mode == 1);
      rst = 1'b0;
      vld = 1'b1;
      abt = 1'b0;
      data = word;
      rx_drive = (mode == 2) ? 1'b1 : 1'($urandom);
      #1;
      chk("idle_ready", 32'(rdy), 32'(1));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_rx_valid", 32'(rx_valid), 32'(0));
      chk("idle_rx_data", 32'(rx_data), 32'(exp_rx));
      @(negedge clk);
      for (int t = 1; t <= T; t++) begin
         stb_e = (t >= 1 + DIV) && (t <= 1 + 16 * DIV) && (((t - 1) % DIV) == 0);
         k = (t - 1) / DIV;
         rst = (t == rst_t);
         vld = keep;
         data = 16'($urandom);
         rx_drive = (mode == 2) ? 1'b1 : 1'($urandom);
         abt = (abort_k != 0) && stb_e && (k == abort_k);
         #1;
         if (rst) begin
            chk("rst_ready", 32'(rdy), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_strobe", 32'(stb), 32'(0));
            chk("rst_tx", 32'(tx), 32'(0));
            chk("rst_rx_valid", 32'(rx_valid), 32'(0));
            chk("rst_rx_data", 32'(rx_data), 32'(0));
            chk("rst_en", 32'(usr_en), 32'(0));
            chk("rst_op", 32'(usr_op), 32'(0));
            chk("rst_par", 32'(usr_par), 32'(0));
            exp_rx = '0;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (busy === 1'b1) busy_seen++;
         s = (t >= 2) ? (t - 2) / DIV : 0;
         tx_e = (t >= 2 && t <= 1 + 16 * DIV) ? (LsbFirst ? word[s] : word[15 - s]) : 1'b0;
         chk("busy", 32'(busy), 32'(1));
         chk("ready", 32'(rdy), 32'(0));
         chk("usr_en", 32'(usr_en), 32'(1));
         chk("serial_tx", 32'(tx), 32'(tx_e));
         chk("usr_par", 32'(usr_par), (t == 1) ? 32'(word) : 32'(0));
         if (!abt) begin
            op_e = (t == 1) ? 2'd3 : (stb_e ? ShiftOp : 2'd0);
            chk("strobe", 32'(stb), 32'(stb_e));
            chk("usr_op", 32'(usr_op), 32'(op_e));
         end
         if (stb_e && !abt) begin
            rx_b = (mode == 1) ? tx_e : rx_drive;
            res = LsbFirst ? {rx_b, res[15:1]} : {res[14:0], rx_b};
            seq = {seq[14:0], tx_e};
         end
         if (t == T) exp_rx = res;
         chk("rx_valid", 32'(rx_valid), 32'(t == T));
         chk("rx_data", 32'(rx_data), 32'(exp_rx));
         @(negedge clk);
         abt = 1'b0;
         if (abort_k != 0 && stb_e && k == abort_k) return;
      end
   endtask

   typedef struct {
      logic        rst;
      logic        vld;
      logic        abt;
      logic [15:0] data;
      logic        rdy;
      logic        busy;
      logic        en;
      logic [1:0]  op;
      logic [15:0] par;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [15:0] w;
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h1357, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 2'd3, 16'h1357};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0000};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0000};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000};

      loop_mode = 1'b0;
      rx_drive = 1'b0;
      for (int i = 0; i < 12; i++) begin
         rst = vecs[i].rst;
         vld = vecs[i].vld;
         abt = vecs[i].abt;
         data = vecs[i].data;
         #1;
         chk("vec_ready", 32'(rdy), 32'(vecs[i].rdy));
         chk("vec_busy", 32'(busy), 32'(vecs[i].busy));
         chk("vec_en", 32'(usr_en), 32'(vecs[i].en));
         chk("vec_op", 32'(usr_op), 32'(vecs[i].op));
         chk("vec_par", 32'(usr_par), 32'(vecs[i].par));
         chk("vec_rx_valid", 32'(rx_valid), 32'(0));
         chk("vec_rx_data", 32'(rx_data), 32'(0));
         @(negedge clk);
      end

      // Loopback of a known word: outgoing bit order and round trip.
      xfer(16'hA5C3, 1, 1'b0, 0, 0, txs);
      chk("loop_tx_order", 32'(txs), LsbFirst ? 32'(16'hC3A5) : 32'(16'hA5C3));
      #1;
      chk("loop_rx_word", 32'(rx_data), 32'(16'hA5C3));

      // Zero word out, ones in: strobe timing, busy length, all-ones result.
      xfer(16'h0000, 2, 1'b0, 0, 0, txs);
      chk("busy_length", 32'(busy_seen), 32'(2 + 16 * DIV));
      #1;
      chk("ones_rx_word", 32'(rx_data), 32'(16'hFFFF));

      // Abort on the 8th shift: no pulse, previous word kept.
      xfer(16'h5A5A, 0, 1'b0, 8, 0, txs);
      #1;
      chk("abort_rx_kept", 32'(rx_data), 32'(16'hFFFF));

      // Reset mid-shift with valid held, then back-to-back loopback words.
      xfer(16'h0F0F, 0, 1'b1, 0, 2 + 5 * DIV + 2, txs);
      xfer(16'h1234, 1, 1'b1, 0, 0, txs);
      xfer(16'h8001, 1, 1'b1, 0, 0, txs);
      #1;
      chk("b2b_rx_word", 32'(rx_data), 32'(16'h8001));

      for (int i = 0; i < 6; i++) begin
         w = 16'($urandom);
         xfer(w, int'($urandom_range(0, 1)), 1'($urandom), 0, 0, txs);
      end

      vld = 1'b0;
      abt = 1'b0;
      #1;
      chk("final_ready", 32'(rdy), 32'(1));
      chk("final_busy", 32'(busy), 32'(0));
      chk("final_rx_data", 32'(rx_data), 32'(exp_rx));
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usr_shift_sequencer.md
USR_SHIFT_SEQUENCER -- requirements
Module: usr_shift_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4, clocks per serial bit (legal range 1..255).
REQ-002 Clk_In  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset_In  input  1  synchronous, active-high reset.
REQ-004 Tx_Valid_In  input  1  requester offers a 16-bit word.
REQ-005 Tx_Ready_Out  output  1  sequencer can accept a word.
REQ-006 Tx_Data_In  input  16  word to transmit.
REQ-007 Abort_In  input  1  cancel the transfer in progress.
REQ-008 Serial_Rx_In  input  1  serial receive bit.
REQ-009 Serial_Tx_Out  output  1  serial transmit bit.
REQ-010 Bit_Strobe_Out  output  1  one-cycle pulse on every shift cycle.
REQ-011 Busy_Out  output  1  high whenever state is not IDLE.
REQ-012 Rx_Valid_Out  output  1  one-cycle pulse: received word valid.
REQ-013 Rx_Data_Out  output  16  received word, held until the next Rx_Valid_Out pulse.
REQ-014 USR_Enable_Out  output  1  drives USR Enable_In.
REQ-015 USR_Operation_Select_Out  output  2  drives USR op select: 0 none, 1 shift left, 2 shift right, 3 load.
REQ-016 USR_Serial_Left_Side_Data_Out / USR_Serial_Right_Side_Data_Out  output  1 each  drive the USR serial inputs; both equal Serial_Rx_In.
REQ-017 USR_Parallel_Data_Out  output  16  drives USR Parallel_Data_In.
REQ-018 USR_Serial_Left_Side_Data_In / USR_Serial_Right_Side_Data_In / USR_Parallel_Data_In  input  1/1/16  USR outputs.

Function
REQ-019 FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE->LOAD on Tx_Valid_In & Tx_Ready_Out.
- LOAD->SHIFT unconditionally.
- SHIFT->DONE after the 16th shift.
- DONE->IDLE unconditionally.
REQ-020 Tx_Ready_Out = (state==IDLE) & !Abort_In; the accepted word is latched on the handshake edge (cycle N).
REQ-021 LOAD (cycle N+1) SHALL drive op=3 and USR_Parallel_Data_Out = latched word; the word appears at the USR output from N+2.
REQ-022 In SHIFT, a 5-bit bit counter and an 8-bit divide counter SHALL issue op=1 (shift left) on every CLK_DIV-th cycle, and op=0 otherwise.
- First shift at cycle N+1+CLK_DIV; 16th shift at N+1+16*CLK_DIV.
REQ-023 Bit_Strobe_Out is high exactly on shift cycles; Serial_Rx_In is captured into USR bit 0 at that edge.
REQ-024 Serial_Tx_Out = USR_Serial_Left_Side_Data_In in SHIFT, 0 otherwise (MSB first).
REQ-025 DONE (cycle N+2+16*CLK_DIV): Rx_Valid_Out=1 and Rx_Data_Out <= USR_Parallel_Data_In (registered).
REQ-026 Busy period is 2+16*CLK_DIV cycles; Tx_Ready_Out returns high the cycle after DONE. Back-to-back words are separated by one IDLE cycle.
REQ-027 USR_Enable_Out=1 in all states after reset; op=0 in IDLE and DONE.
REQ-028 Abort_In high in LOAD or SHIFT -> IDLE at the next edge; no Rx_Valid_Out pulse; Rx_Data_Out unchanged; the USR contents are left as-is.
REQ-029 Abort_In in IDLE or DONE SHALL be ignored except for blocking Tx_Ready_Out; in DONE, Rx_Valid_Out still pulses.
REQ-030 Tx_Data_In changes after the handshake SHALL not affect the transfer.

Reset
REQ-031 Reset_In has priority over all inputs, including Abort_In and an active handshake.
REQ-032 On reset:
- state=IDLE; counters=0.
- Tx_Ready_Out=0 during the reset cycle, 1 the cycle after.
- Rx_Valid_Out=0, Rx_Data_Out=0x0000, Serial_Tx_Out=0, Bit_Strobe_Out=0, Busy_Out=0.
- USR_Enable_Out=0, op=0, USR_Parallel_Data_Out=0x0000.
REQ-033 Reset mid-SHIFT SHALL abandon the transfer silently, with no Rx_Valid_Out pulse.

Configuration
REQ-034 Macro USR_SEQ_LSB_FIRST_EN:
- Defined: shifts use op=2 (shift right); Serial_Tx_Out = USR_Serial_Right_Side_Data_In; Serial_Rx_In enters USR bit 15.
- Undefined: MSB-first as in REQ-022..024.
- Timing is identical in both cases.

Verification
REQ-035 CLK_DIV=1, loopback Serial_Rx_In=Serial_Tx_Out, Tx_Data_In=0xA5C3 -> Serial_Tx_Out 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; Rx_Valid_Out at N+18; Rx_Data_Out=0xA5C3.
REQ-036 CLK_DIV=4, Serial_Rx_In=1, Tx_Data_In=0x0000 -> Bit_Strobe_Out at N+5, N+9 .. N+65; Rx_Data_Out=0xFFFF at N+66; Busy_Out high for 66 cycles.
REQ-037 Abort_In pulsed at the 8th shift cycle -> IDLE next cycle; no Rx_Valid_Out; Rx_Data_Out keeps its previous value; Tx_Ready_Out high one cycle later.
REQ-038 Reset_In asserted mid-SHIFT with Tx_Valid_In held -> every output at its reset value; handshake accepted only on the cycle after reset deasserts.
REQ-039 Tx_Valid_In held continuously with 0x1234 then 0x8001 -> two complete transfers, one IDLE cycle apart; loopback Rx words equal 0x1234 and 0x8001.
REQ-040 USR_SEQ_LSB_FIRST_EN defined, 0xA5C3 -> Serial_Tx_Out 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; op=2 on every strobe.
